// File: rtl/defines_pkg.sv
// Shared types for the ping-pong buffer: per-bank ownership state.
package defines_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_READY = 1'b1
    } bank_state_t;

    localparam int NUM_BANKS = 2;

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank storage, 2*DEPTH x DATA_WIDTH: one write port, one registered read port.
// Address is {bank, ptr}; the read register holds its value when no read is issued.
module pingpong_ram
    import defines_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [AW:0]           i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW:0]           i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int WORDS = NUM_BANKS * (2 ** AW);

    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // NOTE: the array has no reset so it maps onto RAM macros; only the output register is reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pingpong_buffer.sv
// Two-bank ping-pong buffer driven by per-buffer write/read toggle pulses.
// Define PINGPONG_ERR_EN to implement the sticky ovf_err/unf_err flags; otherwise they read 0.
module pingpong_buffer
    import defines_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_toggle,
    input  logic                  i_rd_toggle,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_wr_full,
    output logic                  o_rd_avail,
    output logic                  o_wr_bank,
    output logic                  o_rd_bank,
    output logic                  o_ovf_err,
    output logic                  o_unf_err
);

    localparam int          PW      = AW + 1;
    localparam logic [AW:0] DEPTH_P = PW'(DEPTH);
    localparam logic [AW:0] ONE_P   = PW'(1);

    bank_state_t r_state [NUM_BANKS];
    logic [AW:0] r_cnt   [NUM_BANKS];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_wr_bank;
    logic        r_rd_bank;
    logic        r_rd_valid;

    bank_state_t w_state_nxt [NUM_BANKS];
    logic [AW:0] w_cnt_nxt   [NUM_BANKS];
    logic [AW:0] w_wr_ptr_nxt;
    logic [AW:0] w_rd_ptr_nxt;
    logic        w_wr_bank_nxt;
    logic        w_rd_bank_nxt;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_rdt_acc;
    logic w_wrt_acc;

    // Acceptance decisions; a same-cycle release frees the bank before the writer claims it.
    always_comb begin
        w_wr_acc  = i_wr_en && (r_wr_ptr < DEPTH_P);
        w_rd_acc  = i_rd_en && (r_state[r_rd_bank] == BANK_READY)
                            && (r_rd_ptr < r_cnt[r_rd_bank]);
        w_rdt_acc = i_rd_toggle && (r_state[r_rd_bank] == BANK_READY);
        w_wrt_acc = i_wr_toggle && ((r_state[!r_wr_bank] == BANK_EMPTY)
                                 || (w_rdt_acc && (r_rd_bank != r_wr_bank)));
    end

    // NOTE: every next-state variable gets its default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_wr_bank_nxt = r_wr_bank;
        w_rd_bank_nxt = r_rd_bank;

        if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + ONE_P;
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + ONE_P;
        end

        if (w_rdt_acc) begin
            w_state_nxt[r_rd_bank] = BANK_EMPTY;
            w_rd_bank_nxt          = !r_rd_bank;
            w_rd_ptr_nxt           = '0;
        end

        // The word written on the closing edge still lands in the old bank and is counted.
        if (w_wrt_acc) begin
            w_state_nxt[r_wr_bank] = BANK_READY;
            w_cnt_nxt[r_wr_bank]   = w_wr_acc ? (r_wr_ptr + ONE_P) : r_wr_ptr;
            w_wr_bank_nxt          = !r_wr_bank;
            w_wr_ptr_nxt           = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= '{BANK_EMPTY, BANK_EMPTY};
            r_cnt      <= '{default: '0};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            r_rd_valid <= w_rd_acc;
        end
    end

    pingpong_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr ({r_wr_bank, r_wr_ptr[AW-1:0]}),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr ({r_rd_bank, r_rd_ptr[AW-1:0]}),
        .o_rd_data (o_rd_data)
    );

`ifdef PINGPONG_ERR_EN
    logic r_ovf_err;
    logic r_unf_err;
    logic w_wr_drop;

    assign w_wr_drop = i_wr_en && !w_wr_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            r_ovf_err <= r_ovf_err | w_wr_drop | (i_wr_toggle && !w_wrt_acc);
            r_unf_err <= r_unf_err | (i_rd_toggle && !w_rdt_acc);
        end
    end

    assign o_ovf_err = r_ovf_err;
    assign o_unf_err = r_unf_err;
`else
    assign o_ovf_err = 1'b0;
    assign o_unf_err = 1'b0;
`endif

    assign o_rd_valid = r_rd_valid;
    assign o_wr_full  = (r_wr_ptr == DEPTH_P);
    assign o_rd_avail = (r_state[r_rd_bank] == BANK_READY);
    assign o_wr_bank  = r_wr_bank;
    assign o_rd_bank  = r_rd_bank;

endmodule

// File: doc/pingpong_buffer.md
# pingpong_buffer

Two-bank (ping-pong) data buffer that sits on one dataflow edge between a producing and a consuming actor and obeys the per-buffer write/read toggle pulses emitted by the schedule controller. The writer fills one bank while the reader drains the other; a write toggle closes the filling bank and hands it to the reader, and a read toggle releases the drained bank back to the writer. One instance is placed per buffer index driven by the controller.

## Interface
- DATA_WIDTH, 16, data word width
- DEPTH, 16, words per bank
- AW, $clog2(DEPTH), bank address width
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- wr_toggle  in  1  close current write bank, switch writer to other bank
- rd_toggle  in  1  release current read bank, switch reader to other bank
- wr_en  in  1  write wr_data at wr_ptr of write bank
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read word at rd_ptr of read bank
- rd_data  out  DATA_WIDTH  read data, valid when rd_valid
- rd_valid  out  1  rd_data holds a word read the previous cycle
- wr_full  out  1  wr_ptr == DEPTH; further writes dropped
- rd_avail  out  1  read bank is READY
- wr_bank  out  1  bank currently owned by writer
- rd_bank  out  1  bank currently owned by reader
- ovf_err  out  1  sticky: wr_toggle rejected or write dropped
- unf_err  out  1  sticky: rd_toggle rejected

## Operation
- Per-bank state EMPTY/READY plus count cnt[b] (AW+1 bits). Writer pointer wr_ptr, reader pointer rd_ptr (AW+1 bits each).
- Write: wr_en && wr_ptr < DEPTH → store at {wr_bank, wr_ptr}, wr_ptr+1. wr_en at wr_ptr == DEPTH → dropped, ovf_err set.
- wr_toggle accepted iff bank ~wr_bank is EMPTY, or is being released by rd_toggle in the same cycle (release before claim). On accept: bank[wr_bank] ← READY, cnt[wr_bank] ← wr_ptr (+1 if same-cycle write accepted), wr_bank flips, wr_ptr ← 0. Rejected → no state change except the write itself; ovf_err set.
- Read: rd_en && bank[rd_bank] READY && rd_ptr < cnt[rd_bank] → read {rd_bank, rd_ptr}, rd_ptr+1, rd_valid high next cycle. Otherwise rd_valid low next cycle, rd_data holds.
- rd_toggle accepted iff bank[rd_bank] READY: bank ← EMPTY, rd_bank flips, rd_ptr ← 0. Same-cycle rd_en reads the old bank first. Rejected → unf_err set.
- Zero-length toggle (wr_ptr 0) legal: bank READY with cnt 0, reads yield no valid; released normally.
- Unread words at release are discarded without error.

## Timing
- Reset (async assert, sync deassert in clk domain): wr_bank 0, rd_bank 0, both banks EMPTY, cnt 0, pointers 0, rd_data 0, rd_valid 0, wr_full 0, rd_avail 0, errors 0.
- Read latency 1 cycle (registered). Status outputs are registered, reflect state after the edge.
- Toggle takes effect on the edge it is sampled; first write/read to the new bank is legal the next cycle.
- Steady state with one-cycle toggle spacing sustains 1 word/cycle each side.
- Reset mid-operation discards all contents and pointers immediately.

## Configuration
- PINGPONG_ERR_EN defined: ovf_err/unf_err sticky flags implemented as above.
- Undefined: ovf_err and unf_err tied 0, flag registers removed; rejection/drop behaviour unchanged.

## Structure
- defines_pkg: bank_state_t enum (BANK_EMPTY, BANK_READY).
- Sub-module pingpong_ram: 2*DEPTH × DATA_WIDTH, one write port, one registered read port, address {bank, ptr}.

## Test plan
- Reset, write 0x0001..0x0004, wr_toggle → rd_avail 1, wr_bank 1; 4 rd_en → rd_data 0x0001..0x0004 each one cycle later, 5th rd_en → rd_valid 0.
- Write 16 words then one more → wr_full 1, 17th dropped, ovf_err 1; read back exactly 16 words.
- Bank 0 READY unreleased, writer fills bank 1, wr_toggle → rejected, wr_bank stays 1, ovf_err 1.
- Same cycle rd_toggle (bank 0) and wr_toggle (bank 1) → both accepted, rd_bank 1, wr_bank 0, no error.
- rd_toggle at reset with no data → unf_err 1, rd_bank stays 0.
- Assert rst_n low mid-stream → all outputs return to reset values that cycle; macro undefined → error outputs stay 0 in all above.
